// File: rtl/io_mmio_ctrl.sv
// io_mmio_ctrl: memory-mapped I/O controller on the core's data-memory path.
// Handles lane-correct sub-word stores, sign/zero-extending loads, misalignment
// rejection, seven-segment digit registers and debounced switches with sticky
// rising-edge status bits (write 1 to clear).
module io_mmio_ctrl #(
  parameter int NUM_HEX         = 6,
  parameter int SW_WIDTH        = 32,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  io_enable,
  input  logic                  i_wren,
  input  logic [16:0]           i_address,
  input  logic [2:0]            funct3,
  input  logic [31:0]           i_data,
  input  logic [SW_WIDTH-1:0]   i_io_sw,
  output logic [31:0]           o_data,
  output logic                  o_misaligned,
  output logic [31:0]           o_io_ledr,
  output logic [31:0]           o_io_ledg,
  output logic [31:0]           o_io_lcd,
  output logic [7*NUM_HEX-1:0]  o_io_hex
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Byte k of the 64-bit digit storage exists only for digits below NUM_HEX
  function automatic logic [63:0] hex_mask_f();
    logic [63:0] m;
    m = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < NUM_HEX) m[8*k +: 8] = 8'hFF;
    end
    return m;
  endfunction

  localparam logic [63:0] HEX_MASK    = hex_mask_f();
  localparam logic [31:0] HEX_MASK_LO = HEX_MASK[31:0];
  localparam logic [31:0] HEX_MASK_HI = HEX_MASK[63:32];

  logic [31:0] ledr_q, ledg_q, lcd_q, hex_lo_q, hex_hi_q;
  logic [SW_WIDTH-1:0] sync1_q, sync2_q, deb_q, status_q;
  logic [CNT_W-1:0]    cnt_q [SW_WIDTH];
  logic                mis_q;

  logic [1:0]  size;
  logic        mis;
  logic [3:0]  lane_en;
  logic [31:0] wdata, bit_mask, store_bits;
  logic        we, wr_in, wr_out;
  logic [3:0]  reg_sel;
  logic [SW_WIDTH-1:0] rise, clr;
  logic [31:0] sw_ext, status_ext, word_sel, load_v;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [63:0] hex_all;
  logic        unused_addr_bits;

  assign size    = funct3[1:0];
  assign reg_sel = i_address[15:12];
  assign unused_addr_bits = ^i_address[11:4];

  // Size-dependent alignment check; code 11 behaves as a word access
  always_comb begin
    mis = 1'b0;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = i_address[0];
      default: mis = (i_address[1:0] != 2'b00);
    endcase
  end

  // Lane enables and replicated store data so each lane sees its own bytes
  always_comb begin
    lane_en = 4'hF;
    wdata   = i_data;
    case (size)
      2'b00: begin
        lane_en = 4'b0001 << i_address[1:0];
        wdata   = {4{i_data[7:0]}};
      end
      2'b01: begin
        lane_en = i_address[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{i_data[15:0]}};
      end
      default: begin
        lane_en = 4'hF;
        wdata   = i_data;
      end
    endcase
  end

  assign bit_mask   = {{8{lane_en[3]}}, {8{lane_en[2]}}, {8{lane_en[1]}}, {8{lane_en[0]}}};
  assign store_bits = wdata & bit_mask;
  assign we         = io_enable & i_wren & ~mis;
  assign wr_in      = we & i_address[16];
  assign wr_out     = we & ~i_address[16];
  assign clr        = (wr_in && i_address[3:2] == 2'd1) ? store_bits[SW_WIDTH-1:0] : '0;

  // Output registers: only the enabled lanes of the selected register change
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ledr_q   <= '0;
      ledg_q   <= '0;
      hex_lo_q <= '0;
      hex_hi_q <= '0;
      lcd_q    <= '0;
    end else if (wr_out) begin
      case (reg_sel)
        4'd0: ledr_q   <= (ledr_q & ~bit_mask) | store_bits;
        4'd1: ledg_q   <= (ledg_q & ~bit_mask) | store_bits;
        4'd2: hex_lo_q <= ((hex_lo_q & ~bit_mask) | store_bits) & HEX_MASK_LO;
        4'd3: hex_hi_q <= ((hex_hi_q & ~bit_mask) | store_bits) & HEX_MASK_HI;
        4'd4: lcd_q    <= (lcd_q & ~bit_mask) | store_bits;
        default: ;
      endcase
    end
  end

  // A bit rises when its counter expires while the debounced value is still 0
  always_comb begin
    rise = '0;
    for (int i = 0; i < SW_WIDTH; i++) begin
      rise[i] = (sync2_q[i] != deb_q[i]) && (cnt_q[i] == CNT_LAST) && !deb_q[i];
    end
  end

  // Synchronise, then count stable disagreement before toggling each debounced bit
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < SW_WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= i_io_sw;
      sync2_q <= sync1_q;
      for (int i = 0; i < SW_WIDTH; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (cnt_q[i] == CNT_LAST) begin
            deb_q[i] <= ~deb_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  // Sticky edge status: a new rising edge takes priority over a same-cycle clear
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) status_q <= '0;
    else        status_q <= (status_q & ~clr) | rise;
  end

  // One-cycle pulse after any rejected access seen by this block
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) mis_q <= 1'b0;
    else        mis_q <= io_enable & mis;
  end

  // Zero-extend the switch-side registers to the bus width
  always_comb begin
    sw_ext     = '0;
    status_ext = '0;
    sw_ext[SW_WIDTH-1:0]     = deb_q;
    status_ext[SW_WIDTH-1:0] = status_q;
  end

  // Select the aligned word addressed by the access
  always_comb begin
    word_sel = '0;
    if (i_address[16]) begin
      case (i_address[3:2])
        2'd0:    word_sel = sw_ext;
        2'd1:    word_sel = status_ext;
        default: word_sel = '0;
      endcase
    end else begin
      case (reg_sel)
        4'd0:    word_sel = ledr_q;
        4'd1:    word_sel = ledg_q;
        4'd2:    word_sel = hex_lo_q;
        4'd3:    word_sel = hex_hi_q;
        4'd4:    word_sel = lcd_q;
        default: word_sel = '0;
      endcase
    end
  end

  assign byte_v = 8'(word_sel >> {i_address[1:0], 3'b000});
  assign half_v = i_address[1] ? word_sel[31:16] : word_sel[15:0];

  // Lane extraction and extension by load type
  always_comb begin
    load_v = word_sel;
    case (funct3)
      3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_v = {{16{half_v[15]}}, half_v};
      3'b100:  load_v = {24'd0, byte_v};
      3'b101:  load_v = {16'd0, half_v};
      default: load_v = word_sel;
    endcase
  end

  assign o_data       = (io_enable && !mis) ? load_v : '0;
  assign o_misaligned = mis_q;
  assign o_io_ledr    = ledr_q;
  assign o_io_ledg    = ledg_q;
  assign o_io_lcd     = lcd_q;
  assign hex_all      = {hex_hi_q, hex_lo_q};

  for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex
    assign o_io_hex[7*k +: 7] = hex_all[8*k +: 7];
  end

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// tb_io_mmio_ctrl: directed self-checking bench for io_mmio_ctrl with
// NUM_HEX=6, SW_WIDTH=8, DEBOUNCE_CYCLES=4.
module tb_io_mmio_ctrl;

  localparam int NUM_HEX  = 6;
  localparam int SW_WIDTH = 8;
  localparam int DEB      = 4;

  logic                 i_clk;
  logic                 i_rst;
  logic                 io_enable;
  logic                 i_wren;
  logic [16:0]          i_address;
  logic [2:0]           funct3;
  logic [31:0]          i_data;
  logic [SW_WIDTH-1:0]  i_io_sw;
  logic [31:0]          o_data;
  logic                 o_misaligned;
  logic [31:0]          o_io_ledr, o_io_ledg, o_io_lcd;
  logic [7*NUM_HEX-1:0] o_io_hex;

  int total = 0;
  int bad   = 0;

  io_mmio_ctrl #(
    .NUM_HEX(NUM_HEX),
    .SW_WIDTH(SW_WIDTH),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .io_enable(io_enable),
    .i_wren(i_wren),
    .i_address(i_address),
    .funct3(funct3),
    .i_data(i_data),
    .i_io_sw(i_io_sw),
    .o_data(o_data),
    .o_misaligned(o_misaligned),
    .o_io_ledr(o_io_ledr),
    .o_io_ledg(o_io_ledg),
    .o_io_lcd(o_io_lcd),
    .o_io_hex(o_io_hex)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic drive_idle();
    io_enable = 1'b0;
    i_wren    = 1'b0;
    i_address = '0;
    funct3    = 3'b010;
    i_data    = '0;
  endtask

  // Present a store at the falling edge; it commits on the next rising edge
  task automatic do_store(input logic [16:0] a, input logic [2:0] f, input logic [31:0] d);
    @(negedge i_clk);
    io_enable = 1'b1;
    i_wren    = 1'b1;
    i_address = a;
    funct3    = f;
    i_data    = d;
    @(posedge i_clk);
    #1;
    drive_idle();
  endtask

  // Present a load at the falling edge and sample the combinational result
  task automatic do_load(input logic [16:0] a, input logic [2:0] f, output logic [31:0] d);
    @(negedge i_clk);
    io_enable = 1'b1;
    i_wren    = 1'b0;
    i_address = a;
    funct3    = f;
    #1;
    d = o_data;
  endtask

  task automatic test_reset();
    logic [16:0] addrs [9];
    logic [31:0] d;
    addrs = '{17'h00000, 17'h01000, 17'h02000, 17'h03000, 17'h04000,
              17'h05000, 17'h10000, 17'h10004, 17'h1000C};
    repeat (3) @(posedge i_clk);
    #1;
    total++;
    if ({o_io_ledr, o_io_ledg, o_io_lcd} !== 96'd0 || o_io_hex !== '0 || o_misaligned !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: ledr=%h ledg=%h lcd=%h hex=%h mis=%b expected all 0",
               o_io_ledr, o_io_ledg, o_io_lcd, o_io_hex, o_misaligned);
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    for (int i = 0; i < 9; i++) begin
      do_load(addrs[i], 3'b010, d);
      total++;
      if (d !== 32'd0) begin
        bad++;
        $display("[TB] FAIL reset_read addr=%h: got %h expected 00000000", addrs[i], d);
      end
    end
    drive_idle();
  endtask

  task automatic test_lanes();
    logic [31:0] d;
    do_store(17'h00000, 3'b010, 32'h11223344);
    do_store(17'h00002, 3'b000, 32'h000000AA);
    do_load(17'h00000, 3'b010, d);
    total++;
    if (d !== 32'h11AA3344) begin
      bad++;
      $display("[TB] FAIL sb_lane readback: got %h expected 11aa3344", d);
    end
    drive_idle();
    #1;
    total++;
    if (o_data !== 32'd0) begin
      bad++;
      $display("[TB] FAIL idle_data: got %h expected 00000000", o_data);
    end
    do_store(17'h01000, 3'b010, 32'h00000000);
    do_store(17'h01002, 3'b001, 32'h1234BEEF);
    total++;
    if (o_io_ledg !== 32'hBEEF0000) begin
      bad++;
      $display("[TB] FAIL sh_ledg: got %h expected beef0000", o_io_ledg);
    end
    do_store(17'h04000, 3'b010, 32'hCAFEF00D);
    do_store(17'h04001, 3'b000, 32'h00000012);
    total++;
    if (o_io_lcd !== 32'hCAFE120D) begin
      bad++;
      $display("[TB] FAIL sb_lcd lane1: got %h expected cafe120d", o_io_lcd);
    end
  endtask

  task automatic test_loads();
    logic [31:0] d;
    logic [2:0]  fs   [5];
    logic [16:0] as   [5];
    logic [31:0] exps [5];
    fs   = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    as   = '{17'h00000, 17'h00000, 17'h00000, 17'h00000, 17'h00001};
    exps = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF80F0, 32'h000080F0, 32'hFFFFFF80};
    do_store(17'h00000, 3'b010, 32'h000080F0);
    for (int i = 0; i < 5; i++) begin
      do_load(as[i], fs[i], d);
      total++;
      if (d !== exps[i]) begin
        bad++;
        $display("[TB] FAIL load f3=%b addr=%h: got %h expected %h", fs[i], as[i], d, exps[i]);
      end
    end
    do_load(17'h00002, 3'b010, d);
    total++;
    if (d !== 32'd0) begin
      bad++;
      $display("[TB] FAIL misaligned_lw data: got %h expected 00000000", d);
    end
    @(posedge i_clk);
    #1;
    drive_idle();
    total++;
    if (o_misaligned !== 1'b1) begin
      bad++;
      $display("[TB] FAIL misaligned_lw pulse: got %b expected 1", o_misaligned);
    end
    @(posedge i_clk);
    #1;
    total++;
    if (o_misaligned !== 1'b0) begin
      bad++;
      $display("[TB] FAIL misaligned_lw pulse end: got %b expected 0", o_misaligned);
    end
    do_store(17'h00001, 3'b010, 32'hDEADBEEF);
    total++;
    if (o_misaligned !== 1'b1) begin
      bad++;
      $display("[TB] FAIL misaligned_sw pulse: got %b expected 1", o_misaligned);
    end
    total++;
    if (o_io_ledr !== 32'h000080F0) begin
      bad++;
      $display("[TB] FAIL misaligned_sw ledr: got %h expected 000080f0", o_io_ledr);
    end
  endtask

  task automatic test_hex();
    logic [31:0] d;
    do_store(17'h02000, 3'b010, 32'h7F404079);
    do_store(17'h03001, 3'b000, 32'h00000024);
    total++;
    if (o_io_hex[6:0] !== 7'h79 || o_io_hex[27:21] !== 7'h7F ||
        o_io_hex[41:35] !== 7'h24 || o_io_hex[34:28] !== 7'h00) begin
      bad++;
      $display("[TB] FAIL hex_digits: got d0=%h d3=%h d4=%h d5=%h expected 79 7f 00 24",
               o_io_hex[6:0], o_io_hex[27:21], o_io_hex[34:28], o_io_hex[41:35]);
    end
    total++;
    if (o_io_hex[20:7] !== 14'h2040) begin
      bad++;
      $display("[TB] FAIL hex_d1d2: got %h expected 2040", o_io_hex[20:7]);
    end
    do_store(17'h03000, 3'b010, 32'hFFFFFFFF);
    do_load(17'h03000, 3'b010, d);
    total++;
    if (d !== 32'h0000FFFF) begin
      bad++;
      $display("[TB] FAIL hex_unused_digits: got %h expected 0000ffff", d);
    end
    do_store(17'h02000, 3'b000, 32'h00000080);
    do_load(17'h02000, 3'b100, d);
    total++;
    if (d !== 32'h00000080 || o_io_hex[6:0] !== 7'h00) begin
      bad++;
      $display("[TB] FAIL hex_bit7: got read=%h d0=%h expected 00000080 00", d, o_io_hex[6:0]);
    end
    drive_idle();
  endtask

  task automatic test_debounce();
    logic [31:0] d;
    @(negedge i_clk);
    i_io_sw = 8'h01;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_io_sw = 8'h00;
    repeat (10) @(posedge i_clk);
    do_load(17'h10000, 3'b010, d);
    total++;
    if (d !== 32'd0) begin
      bad++;
      $display("[TB] FAIL glitch switches: got %h expected 00000000", d);
    end
    @(negedge i_clk);
    i_io_sw   = 8'h01;
    io_enable = 1'b1;
    i_wren    = 1'b0;
    i_address = 17'h10000;
    funct3    = 3'b010;
    for (int e = 1; e <= DEB + 2; e++) begin
      @(posedge i_clk);
      #1;
      if (e == DEB + 1) begin
        total++;
        if (o_data !== 32'd0) begin
          bad++;
          $display("[TB] FAIL debounce early edge %0d: got %h expected 00000000", e, o_data);
        end
      end
      if (e == DEB + 2) begin
        total++;
        if (o_data !== 32'd1) begin
          bad++;
          $display("[TB] FAIL debounce edge %0d: got %h expected 00000001", e, o_data);
        end
      end
    end
    do_load(17'h10004, 3'b010, d);
    total++;
    if (d !== 32'd1) begin
      bad++;
      $display("[TB] FAIL status_set: got %h expected 00000001", d);
    end
    do_store(17'h10004, 3'b010, 32'h00000001);
    do_load(17'h10004, 3'b010, d);
    total++;
    if (d !== 32'd0) begin
      bad++;
      $display("[TB] FAIL status_clear: got %h expected 00000000", d);
    end
    @(negedge i_clk);
    drive_idle();
    i_io_sw = 8'h00;
    repeat (10) @(posedge i_clk);
    @(negedge i_clk);
    i_io_sw = 8'h01;
    repeat (DEB + 1) @(posedge i_clk);
    do_store(17'h10004, 3'b010, 32'h00000001);
    do_load(17'h10004, 3'b010, d);
    total++;
    if (d !== 32'd1) begin
      bad++;
      $display("[TB] FAIL set_wins_clear: got %h expected 00000001", d);
    end
    do_store(17'h10004, 3'b000, 32'h00000001);
    do_load(17'h10004, 3'b010, d);
    total++;
    if (d !== 32'd0) begin
      bad++;
      $display("[TB] FAIL status_clear_byte: got %h expected 00000000", d);
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    @(negedge i_clk);
    i_io_sw = 8'h00;
    repeat (10) @(posedge i_clk);
    do_store(17'h00000, 3'b010, 32'h00000055);
    do_store(17'h02000, 3'b010, 32'h0000003F);
    @(negedge i_clk);
    i_io_sw = 8'h01;
    repeat (3) @(posedge i_clk);
    #2;
    i_rst = 1'b0;
    #1;
    total++;
    if (o_io_ledr !== 32'd0 || o_io_hex !== '0) begin
      bad++;
      $display("[TB] FAIL async_reset: got ledr=%h hex=%h expected 0", o_io_ledr, o_io_hex);
    end
    @(negedge i_clk);
    i_rst     = 1'b1;
    io_enable = 1'b1;
    i_wren    = 1'b0;
    i_address = 17'h10000;
    funct3    = 3'b010;
    for (int e = 1; e <= DEB + 2; e++) begin
      @(posedge i_clk);
      #1;
      if (e == DEB + 1) begin
        total++;
        if (o_data !== 32'd0) begin
          bad++;
          $display("[TB] FAIL requalify early edge %0d: got %h expected 00000000", e, o_data);
        end
      end
      if (e == DEB + 2) begin
        total++;
        if (o_data !== 32'd1) begin
          bad++;
          $display("[TB] FAIL requalify edge %0d: got %h expected 00000001", e, o_data);
        end
      end
    end
    do_load(17'h00000, 3'b010, d);
    total++;
    if (d !== 32'd0) begin
      bad++;
      $display("[TB] FAIL ledr_after_reset: got %h expected 00000000", d);
    end
    drive_idle();
  endtask

  // Overall time bound so a stuck run still ends with a report
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    i_rst   = 1'b0;
    i_io_sw = '0;
    drive_idle();
    test_reset();
    test_lanes();
    test_loads();
    test_hex();
    test_debounce();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
